// File: rtl/note_lane_scheduler_if.sv
// Bundle between the note lane scheduler, its song-table RAM and the VGA datapath.
// The scheduler takes the master side; the RAM/timing/display side takes the slave side.
interface note_lane_scheduler_if #(
    parameter int SONG_DEPTH = 64,
    parameter int DUR_WIDTH  = 8
);
    localparam int AW = $clog2(SONG_DEPTH);

    logic                 frame_tick;
    logic                 start;
    logic                 pause;
    logic [AW-1:0]        rom_addr;
    logic [DUR_WIDTH+4:0] rom_data;
    logic [9:0]           lane_lower;
    logic [9:0]           lane_upper;
    logic [3:0]           lane_idx;
    logic                 note_valid;
    logic                 playing;
    logic                 done;

    modport master (
        input  frame_tick, start, pause, rom_data,
        output rom_addr, lane_lower, lane_upper, lane_idx, note_valid, playing, done
    );

    modport slave (
        output frame_tick, start, pause, rom_data,
        input  rom_addr, lane_lower, lane_upper, lane_idx, note_valid, playing, done
    );
endinterface

// File: rtl/note_lane_scheduler.sv
// Walks the karaoke song table and drives the highlighted-lane pixel bounds.
// New notes only commit on a frame edge, so the lane never changes mid-frame.
module note_lane_scheduler #(
    parameter int NOTE_WIDTH_PX = 40,
    parameter int LANE_COUNT    = 16,
    parameter int SONG_DEPTH    = 64,
    parameter int DUR_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    note_lane_scheduler_if.master sched_io
);
    localparam int              AW         = $clog2(SONG_DEPTH);
    localparam logic [4:0]      LANE_LIMIT = 5'(LANE_COUNT);
    localparam logic [3:0]      LAST_LANE  = 4'(LANE_COUNT - 1);
    localparam logic [9:0]      WIDTH_PX   = 10'(NOTE_WIDTH_PX);
    localparam logic [AW-1:0]   LAST_ADDR  = AW'(SONG_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ARMED, PLAY, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   tickPrev_q, tickPrev_d;
    logic                   frameFlag_q, frameFlag_d;
    logic                   committed_q, committed_d;
    logic [AW-1:0]          romAddr_q, romAddr_d;
    logic                   pendRest_q, pendRest_d;
    logic [3:0]             pendLane_q, pendLane_d;
    logic [DUR_WIDTH-1:0]   pendDur_q, pendDur_d;
    logic [DUR_WIDTH-1:0]   counter_q, counter_d;
    logic [9:0]             laneLower_q, laneLower_d;
    logic [9:0]             laneUpper_q, laneUpper_d;
    logic [3:0]             laneIdx_q, laneIdx_d;
    logic                   noteValid_q, noteValid_d;
    logic                   done_q, done_d;

    logic                   tickEdge;
    logic                   frameEvent;
    logic [3:0]             clampedLane;
    logic [9:0]             lowerPx;
    logic [9:0]             upperPx;
    logic [AW-1:0]          nextAddr;

    assign tickEdge    = sched_io.frame_tick & ~tickPrev_q;
    // A latched edge from FETCH/LOAD counts like a live one; pause swallows both.
    assign frameEvent  = (tickEdge | frameFlag_q) & ~sched_io.pause;
    assign clampedLane = ({1'b0, pendLane_q} >= LANE_LIMIT) ? LAST_LANE : pendLane_q;
    assign lowerPx     = 10'(clampedLane) * WIDTH_PX;
    assign upperPx     = lowerPx + WIDTH_PX;
    assign nextAddr    = (romAddr_q == LAST_ADDR) ? '0 : romAddr_q + AW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            tickPrev_q  <= 1'b0;
            frameFlag_q <= 1'b0;
            committed_q <= 1'b0;
            romAddr_q   <= '0;
            pendRest_q  <= 1'b0;
            pendLane_q  <= '0;
            pendDur_q   <= '0;
            counter_q   <= '0;
            laneLower_q <= '0;
            laneUpper_q <= '0;
            laneIdx_q   <= '0;
            noteValid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tickPrev_q  <= tickPrev_d;
            frameFlag_q <= frameFlag_d;
            committed_q <= committed_d;
            romAddr_q   <= romAddr_d;
            pendRest_q  <= pendRest_d;
            pendLane_q  <= pendLane_d;
            pendDur_q   <= pendDur_d;
            counter_q   <= counter_d;
            laneLower_q <= laneLower_d;
            laneUpper_q <= laneUpper_d;
            laneIdx_q   <= laneIdx_d;
            noteValid_q <= noteValid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tickPrev_d  = sched_io.frame_tick;
        frameFlag_d = frameFlag_q;
        committed_d = committed_q;
        romAddr_d   = romAddr_q;
        pendRest_d  = pendRest_q;
        pendLane_d  = pendLane_q;
        pendDur_d   = pendDur_q;
        counter_d   = counter_q;
        laneLower_d = laneLower_q;
        laneUpper_d = laneUpper_q;
        laneIdx_d   = laneIdx_q;
        noteValid_d = noteValid_q;
        done_d      = 1'b0;

        // Start beats everything, including a frame edge in the same cycle.
        if (sched_io.start) begin
            state_d     = FETCH;
            romAddr_d   = '0;
            frameFlag_d = 1'b0;
            committed_d = 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    frameFlag_d = frameFlag_q | tickEdge;
                    state_d     = LOAD;
                end
                LOAD: begin
                    frameFlag_d = frameFlag_q | tickEdge;
                    pendRest_d  = sched_io.rom_data[DUR_WIDTH+4];
                    pendLane_d  = sched_io.rom_data[DUR_WIDTH+3 -: 4];
                    pendDur_d   = sched_io.rom_data[DUR_WIDTH-1:0];
                    state_d     = committed_q ? PLAY : ARMED;
                end
                ARMED, PLAY: begin
                    frameFlag_d = 1'b0;
                    if (frameEvent) begin
                        if (state_q == PLAY && counter_q > DUR_WIDTH'(1)) begin
                            counter_d = counter_q - DUR_WIDTH'(1);
                        end else if (pendDur_q == '0) begin
                            laneLower_d = '0;
                            laneUpper_d = '0;
                            noteValid_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = DONE;
                        end else begin
                            laneIdx_d   = clampedLane;
                            noteValid_d = ~pendRest_q;
                            laneLower_d = pendRest_q ? 10'd0 : lowerPx;
                            laneUpper_d = pendRest_q ? 10'd0 : upperPx;
                            counter_d   = pendDur_q;
                            committed_d = 1'b1;
                            romAddr_d   = nextAddr;
                            state_d     = FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sched_io.playing = 1'b0;
        unique case (state_q)
            FETCH, LOAD, ARMED, PLAY: sched_io.playing = 1'b1;
            default:                  sched_io.playing = 1'b0;
        endcase
    end

    assign sched_io.rom_addr   = romAddr_q;
    assign sched_io.lane_lower = laneLower_q;
    assign sched_io.lane_upper = laneUpper_q;
    assign sched_io.lane_idx   = laneIdx_q;
    assign sched_io.note_valid = noteValid_q;
    assign sched_io.done       = done_q;
endmodule
